// File: rtl/tl_pkg.sv
// Shared types and constants for the transaction-layer egress merge path.
// Holds the word layout, FSM state encoding and counter read-back select codes.
package tl_pkg;

  localparam int DATA_W  = 12;
  localparam int CLS_LSB = 8;
  localparam int CLS_MSB = 9;
  localparam int NSRC    = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } tl_state_e;

  localparam logic [2:0] IDX_P0  = 3'd0;
  localparam logic [2:0] IDX_P1  = 3'd1;
  localparam logic [2:0] IDX_P2  = 3'd2;
  localparam logic [2:0] IDX_P3  = 3'd3;
  localparam logic [2:0] IDX_OCC = 3'd4;

  // Stamp the source class into the class field of a forwarded word.
  function automatic logic [DATA_W-1:0] tag_class(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        cls);
    logic [DATA_W-1:0] t;
    t = word;
    t[CLS_MSB:CLS_LSB] = cls;
    return t;
  endfunction

endpackage

// File: rtl/tl_sync_fifo.sv
// Single-clock FIFO with combinational head word; pushes while full and pops
// while empty are ignored, so callers decide what those events mean.
module tl_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_en_s = push && (count_r != CNT_W'(DEPTH));
  assign rd_en_s = pop && (count_r != '0);
  assign rdata   = mem_r[rd_ptr_r];
  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;

  // Storage array; contents are don't-care whenever the count says empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (rd_en_s) rd_ptr_r <= next_ptr(rd_ptr_r);
      count_r <= count_r + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
    end
  end

endmodule

// File: rtl/tl_merge_arbiter.sv
// Merges four per-class input queues into one output queue with a strict-priority
// arbiter (P0 highest), threshold throttling and per-source forwarded-word counters.
module tl_merge_arbiter
  import tl_pkg::*;
#(
  parameter int         IN_DEPTH   = 4,
  parameter int         OUT_DEPTH  = 8,
  parameter int         CNT_W      = 5,
  parameter logic [2:0] UB_DEFAULT = 3'd1,
  parameter logic [2:0] UA_DEFAULT = 3'd6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        umbral_bajo,
  input  logic [2:0]        umbral_alto,
  input  logic              push_in_p0,
  input  logic              push_in_p1,
  input  logic              push_in_p2,
  input  logic              push_in_p3,
  input  logic [DATA_W-1:0] data_in_p0,
  input  logic [DATA_W-1:0] data_in_p1,
  input  logic [DATA_W-1:0] data_in_p2,
  input  logic [DATA_W-1:0] data_in_p3,
  output logic              full_in_p0,
  output logic              full_in_p1,
  output logic              full_in_p2,
  output logic              full_in_p3,
  input  logic              pop_out,
  output logic [DATA_W-1:0] data_out,
  output logic              empty_out,
  output logic              almost_full_out,
  output logic              almost_empty_out,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic              counter_valid,
  output logic [CNT_W-1:0]  counter_out,
  output logic              idle,
  output logic              error
);

  localparam int ICNT_W = $clog2(IN_DEPTH + 1);
  localparam int OCNT_W = $clog2(OUT_DEPTH + 1);

  logic [DATA_W-1:0] din_s   [NSRC];
  logic [DATA_W-1:0] head_s  [NSRC];
  logic [ICNT_W-1:0] icount_s[NSRC];
  logic [NSRC-1:0]   push_s, pop_s, full_s, empty_s, nonempty_next_s;
  logic [1:0]        src_s;
  logic              grant_s, room_s, out_pop_s, out_full_s, out_empty_s, err_set_s;
  logic [DATA_W-1:0] fwd_s, out_head_s;
  logic [OCNT_W-1:0] out_count_s, out_count_next_s;
  logic [2:0]        ub_next_s, ua_next_s, ub_r, ua_r;
  logic [CNT_W-1:0]  sel_s, cout_r;
  logic [CNT_W-1:0]  cnt_r [NSRC];
  logic [DATA_W-1:0] data_out_r;
  logic              af_r, ae_r, cval_r, err_r, idle_r;
  tl_state_e         state_r, state_next_s;

  assign din_s[0] = data_in_p0;
  assign din_s[1] = data_in_p1;
  assign din_s[2] = data_in_p2;
  assign din_s[3] = data_in_p3;
  assign push_s   = {push_in_p3, push_in_p2, push_in_p1, push_in_p0};
  assign {full_in_p3, full_in_p2, full_in_p1, full_in_p0} = full_s;

  for (genvar k = 0; k < NSRC; k++) begin : g_in
    tl_sync_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_W)) u_fifo (
      .clk(clk), .reset(reset), .push(push_s[k]), .pop(pop_s[k]), .wdata(din_s[k]),
      .rdata(head_s[k]), .full(full_s[k]), .empty(empty_s[k]), .count(icount_s[k])
    );
  end

  tl_sync_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_W)) u_out_fifo (
    .clk(clk), .reset(reset), .push(grant_s), .pop(pop_out), .wdata(fwd_s),
    .rdata(out_head_s), .full(out_full_s), .empty(out_empty_s), .count(out_count_s)
  );

  // Strict-priority grant, gated by the registered occupancy against the high threshold.
  always_comb begin
    grant_s = 1'b0;
    src_s   = 2'd0;
    room_s  = (out_count_s < OCNT_W'(ua_r)) && !out_full_s;
    if ((state_r == ST_ACTIVE) && room_s) begin
      if (!empty_s[0]) begin
        grant_s = 1'b1; src_s = 2'd0;
      end else if (!empty_s[1]) begin
        grant_s = 1'b1; src_s = 2'd1;
      end else if (!empty_s[2]) begin
        grant_s = 1'b1; src_s = 2'd2;
      end else if (!empty_s[3]) begin
        grant_s = 1'b1; src_s = 2'd3;
      end else begin
        grant_s = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
    end
    pop_s = grant_s ? (NSRC'(1) << src_s) : '0;
    fwd_s = tag_class(head_s[src_s], src_s);
  end

  // Post-edge occupancy: lets IDLE wake on the push edge so a word moves one edge later.
  always_comb begin
    nonempty_next_s = '0;
    for (int k = 0; k < NSRC; k++) begin
      nonempty_next_s[k] = (icount_s[k] + ICNT_W'(push_s[k] && !full_s[k])
                            - ICNT_W'(pop_s[k])) != '0;
    end
    out_pop_s        = pop_out && !out_empty_s;
    out_count_next_s = out_count_s + OCNT_W'(grant_s) - OCNT_W'(out_pop_s);
    err_set_s        = (pop_out && out_empty_s) || (|(push_s & full_s));
  end

  // Next-state logic and threshold capture window.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RESET:  state_next_s = init ? ST_INIT : ST_IDLE;
      ST_INIT:   state_next_s = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   state_next_s = init ? ST_INIT : (|nonempty_next_s ? ST_ACTIVE : ST_IDLE);
      ST_ACTIVE: state_next_s = init ? ST_INIT : (|nonempty_next_s ? ST_ACTIVE : ST_IDLE);
      default:   state_next_s = ST_RESET;
    endcase
    if ((state_r == ST_INIT) && init) begin
      ub_next_s = umbral_bajo;
      ua_next_s = umbral_alto;
    end else begin
      ub_next_s = ub_r;
      ua_next_s = ua_r;
    end
  end

  // Counter read-back select; unused codes read as zero.
  always_comb begin
    case (idx)
      IDX_P0:  sel_s = cnt_r[0];
      IDX_P1:  sel_s = cnt_r[1];
      IDX_P2:  sel_s = cnt_r[2];
      IDX_P3:  sel_s = cnt_r[3];
      IDX_OCC: sel_s = CNT_W'(out_count_s);
      default: sel_s = '0;
    endcase
  end

  // State, thresholds, output word, flags, counters and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RESET;
      ub_r       <= UB_DEFAULT;
      ua_r       <= UA_DEFAULT;
      data_out_r <= '0;
      af_r       <= 1'b0;
      ae_r       <= 1'b1;
      cval_r     <= 1'b0;
      cout_r     <= '0;
      err_r      <= 1'b0;
      idle_r     <= 1'b0;
      for (int k = 0; k < NSRC; k++) cnt_r[k] <= '0;
    end else begin
      state_r <= state_next_s;
      ub_r    <= ub_next_s;
      ua_r    <= ua_next_s;
      if (out_pop_s) data_out_r <= out_head_s;
      af_r    <= (out_count_next_s >= OCNT_W'(ua_next_s));
      ae_r    <= (out_count_next_s <= OCNT_W'(ub_next_s));
      if (grant_s) cnt_r[src_s] <= cnt_r[src_s] + CNT_W'(1);
      cval_r  <= req;
      if (req) cout_r <= sel_s;
      if (err_set_s) err_r <= 1'b1;
      idle_r  <= (state_next_s == ST_IDLE);
    end
  end

  assign data_out         = data_out_r;
  assign empty_out        = out_empty_s;
  assign almost_full_out  = af_r;
  assign almost_empty_out = ae_r;
  assign counter_valid    = cval_r;
  assign counter_out      = cout_r;
  assign idle             = idle_r;
  assign error            = err_r;

endmodule

// File: tb/tb_tl_merge_arbiter.sv
// Directed self-checking bench for tl_merge_arbiter: one task per scenario.
module tb_tl_merge_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1, init = 1'b0;
  logic [2:0]  umbral_bajo = 3'd1, umbral_alto = 3'd6;
  logic        push_in_p0 = 1'b0, push_in_p1 = 1'b0, push_in_p2 = 1'b0, push_in_p3 = 1'b0;
  logic [11:0] data_in_p0 = 12'h000, data_in_p1 = 12'h000, data_in_p2 = 12'h000, data_in_p3 = 12'h000;
  logic        full_in_p0, full_in_p1, full_in_p2, full_in_p3;
  logic        pop_out = 1'b0;
  logic [11:0] data_out;
  logic        empty_out, almost_full_out, almost_empty_out;
  logic        req = 1'b0;
  logic [2:0]  idx = 3'd0;
  logic        counter_valid;
  logic [4:0]  counter_out;
  logic        idle, error;

  int checks = 0;
  int failures = 0;

  tl_merge_arbiter dut (
    .clk(clk), .reset(reset), .init(init), .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .push_in_p0(push_in_p0), .push_in_p1(push_in_p1), .push_in_p2(push_in_p2), .push_in_p3(push_in_p3),
    .data_in_p0(data_in_p0), .data_in_p1(data_in_p1), .data_in_p2(data_in_p2), .data_in_p3(data_in_p3),
    .full_in_p0(full_in_p0), .full_in_p1(full_in_p1), .full_in_p2(full_in_p2), .full_in_p3(full_in_p3),
    .pop_out(pop_out), .data_out(data_out), .empty_out(empty_out),
    .almost_full_out(almost_full_out), .almost_empty_out(almost_empty_out),
    .req(req), .idx(idx), .counter_valid(counter_valid), .counter_out(counter_out),
    .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic init_v);
    reset = 1'b1; init = init_v; pop_out = 1'b0; req = 1'b0;
    push_in_p0 = 1'b0; push_in_p1 = 1'b0; push_in_p2 = 1'b0; push_in_p3 = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic push_word(input int p, input logic [11:0] d);
    case (p)
      0: begin push_in_p0 = 1'b1; data_in_p0 = d; end
      1: begin push_in_p1 = 1'b1; data_in_p1 = d; end
      2: begin push_in_p2 = 1'b1; data_in_p2 = d; end
      default: begin push_in_p3 = 1'b1; data_in_p3 = d; end
    endcase
    step();
    push_in_p0 = 1'b0; push_in_p1 = 1'b0; push_in_p2 = 1'b0; push_in_p3 = 1'b0;
  endtask

  task automatic read_cnt(input logic [2:0] sel);
    req = 1'b1; idx = sel;
    step();
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd0;
    step(); step();
    checks++; if (data_out !== 12'h000) begin failures++; $display("FAIL rst_data_out got=%h exp=000", data_out); end
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty_out); end
    checks++; if (almost_empty_out !== 1'b1) begin failures++; $display("FAIL rst_almost_empty got=%b exp=1", almost_empty_out); end
    checks++; if (almost_full_out !== 1'b0) begin failures++; $display("FAIL rst_almost_full got=%b exp=0", almost_full_out); end
    checks++; if ({full_in_p3, full_in_p2, full_in_p1, full_in_p0} !== 4'b0000) begin failures++; $display("FAIL rst_full_in got=%b exp=0000", {full_in_p3, full_in_p2, full_in_p1, full_in_p0}); end
    checks++; if ({counter_valid, counter_out} !== 6'd0) begin failures++; $display("FAIL rst_counter got=%b/%0d exp=0/0", counter_valid, counter_out); end
    checks++; if ({error, idle} !== 2'b00) begin failures++; $display("FAIL rst_error_idle got=%b exp=00", {error, idle}); end
    reset = 1'b0;
    step(); step();
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL init_idle got=%b exp=0", idle); end
    init = 1'b0;
    step();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL post_init_idle got=%b exp=1", idle); end
    umbral_alto = 3'd2; umbral_bajo = 3'd3;
  endtask

  task automatic test_priority();
    push_in_p3 = 1'b1; data_in_p3 = 12'h001;
    push_in_p0 = 1'b1; data_in_p0 = 12'h002;
    step();
    push_in_p3 = 1'b0; push_in_p0 = 1'b0;
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL prio_latency_empty got=%b exp=1", empty_out); end
    step();
    checks++; if (empty_out !== 1'b0) begin failures++; $display("FAIL prio_first_xfer got=%b exp=0", empty_out); end
    checks++; if (almost_empty_out !== 1'b0) begin failures++; $display("FAIL prio_ub_latched got=%b exp=0", almost_empty_out); end
    step();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL prio_back_idle got=%b exp=1", idle); end
    pop_out = 1'b1;
    step();
    checks++; if (data_out !== 12'h002) begin failures++; $display("FAIL prio_word0 got=%h exp=002", data_out); end
    step();
    pop_out = 1'b0;
    checks++; if (data_out !== 12'h301) begin failures++; $display("FAIL prio_word1 got=%h exp=301", data_out); end
    checks++; if (empty_out !== 1'b1) begin failures++; $display("FAIL prio_drained got=%b exp=1", empty_out); end
    read_cnt(3'd0);
    checks++; if ({counter_valid, counter_out} !== {1'b1, 5'd1}) begin failures++; $display("FAIL prio_cnt0 got=%b/%0d exp=1/1", counter_valid, counter_out); end
    read_cnt(3'd1);
    checks++; if (counter_out !== 5'd0) begin failures++; $display("FAIL prio_cnt1 got=%0d exp=0", counter_out); end
    read_cnt(3'd3);
    checks++; if (counter_out !== 5'd1) begin failures++; $display("FAIL prio_cnt3 got=%0d exp=1", counter_out); end
    idx = 3'd6;
    step();
    checks++; if ({counter_valid, counter_out} !== {1'b0, 5'd1}) begin failures++; $display("FAIL prio_hold got=%b/%0d exp=0/1", counter_valid, counter_out); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 8; i++) push_word(1, 12'hF00 + 12'(i));
    step(); step();
    checks++; if (almost_full_out !== 1'b1) begin failures++; $display("FAIL thr_almost_full got=%b exp=1", almost_full_out); end
    checks++; if ({full_in_p1, error, idle} !== 3'b000) begin failures++; $display("FAIL thr_full_err_idle got=%b exp=000", {full_in_p1, error, idle}); end
    read_cnt(3'd4);
    checks++; if (counter_out !== 5'd6) begin failures++; $display("FAIL thr_occupancy got=%0d exp=6", counter_out); end
    read_cnt(3'd1);
    checks++; if (counter_out !== 5'd6) begin failures++; $display("FAIL thr_cnt1 got=%0d exp=6", counter_out); end
    pop_out = 1'b1;
    step();
    pop_out = 1'b0;
    checks++; if (data_out !== 12'hD00) begin failures++; $display("FAIL thr_pop_word got=%h exp=d00", data_out); end
    checks++; if (almost_full_out !== 1'b0) begin failures++; $display("FAIL thr_af_drop got=%b exp=0", almost_full_out); end
    step();
    checks++; if (almost_full_out !== 1'b1) begin failures++; $display("FAIL thr_af_refill got=%b exp=1", almost_full_out); end
    read_cnt(3'd1);
    checks++; if (counter_out !== 5'd7) begin failures++; $display("FAIL thr_cnt1_after got=%0d exp=7", counter_out); end
  endtask

  task automatic test_overflow();
    umbral_alto = 3'd0; umbral_bajo = 3'd1;
    do_reset(1'b1);
    step();
    for (int i = 0; i < 4; i++) push_word(2, 12'h010 + 12'(i));
    checks++; if ({full_in_p2, error} !== 2'b10) begin failures++; $display("FAIL ovf_full_noerr got=%b exp=10", {full_in_p2, error}); end
    push_word(2, 12'h014);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf_error got=%b exp=1", error); end
    init = 1'b0;
    step(); step(); step();
    checks++; if ({empty_out, full_in_p2} !== 2'b11) begin failures++; $display("FAIL ovf_ua0_stall got=%b exp=11", {empty_out, full_in_p2}); end
    checks++; if (almost_full_out !== 1'b1) begin failures++; $display("FAIL ovf_ua0_af got=%b exp=1", almost_full_out); end
    read_cnt(3'd2);
    checks++; if (counter_out !== 5'd0) begin failures++; $display("FAIL ovf_cnt2 got=%0d exp=0", counter_out); end
    do_reset(1'b0);
    pop_out = 1'b1;
    step();
    pop_out = 1'b0;
    checks++; if ({error, empty_out, data_out} !== {2'b11, 12'h000}) begin failures++; $display("FAIL underflow got=%b%b/%h exp=11/000", error, empty_out, data_out); end
  endtask

  task automatic test_counter_wrap();
    do_reset(1'b0);
    for (int i = 0; i < 33; i++) begin
      push_word(0, 12'h0C0 + 12'(i));
      step();
      pop_out = 1'b1;
      step();
      pop_out = 1'b0;
    end
    checks++; if ({error, data_out} !== {1'b0, 12'h0E0}) begin failures++; $display("FAIL wrap_last_word got=%b/%h exp=0/0e0", error, data_out); end
    read_cnt(3'd0);
    checks++; if ({counter_valid, counter_out} !== {1'b1, 5'd1}) begin failures++; $display("FAIL wrap_cnt0 got=%b/%0d exp=1/1", counter_valid, counter_out); end
    push_word(0, 12'h100);
    push_word(0, 12'h101);
    step(); step();
    read_cnt(3'd4);
    checks++; if (counter_out !== 5'd2) begin failures++; $display("FAIL wrap_occupancy got=%0d exp=2", counter_out); end
    read_cnt(3'd0);
    checks++; if (counter_out !== 5'd3) begin failures++; $display("FAIL wrap_cnt0_again got=%0d exp=3", counter_out); end
    read_cnt(3'd6);
    checks++; if ({counter_valid, counter_out} !== {1'b1, 5'd0}) begin failures++; $display("FAIL wrap_idx6 got=%b/%0d exp=1/0", counter_valid, counter_out); end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    pop_out = 1'b1;
    step();
    pop_out = 1'b0;
    push_word(0, 12'h111);
    push_word(0, 12'h222);
    push_word(0, 12'h333);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({empty_out, error, almost_empty_out} !== 3'b101) begin failures++; $display("FAIL mrst_flags got=%b exp=101", {empty_out, error, almost_empty_out}); end
    checks++; if (data_out !== 12'h000) begin failures++; $display("FAIL mrst_data got=%h exp=000", data_out); end
    step(); step(); step(); step(); step();
    checks++; if ({empty_out, idle} !== 2'b11) begin failures++; $display("FAIL mrst_no_stale got=%b exp=11", {empty_out, idle}); end
    read_cnt(3'd0);
    checks++; if (counter_out !== 5'd0) begin failures++; $display("FAIL mrst_cnt0 got=%0d exp=0", counter_out); end
    read_cnt(3'd4);
    checks++; if (counter_out !== 5'd0) begin failures++; $display("FAIL mrst_occupancy got=%0d exp=0", counter_out); end
    push_word(2, 12'h555);
    step();
    pop_out = 1'b1;
    step();
    pop_out = 1'b0;
    checks++; if (data_out !== 12'h655) begin failures++; $display("FAIL mrst_fresh_word got=%h exp=655", data_out); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_threshold();
    test_overflow();
    test_counter_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_merge_arbiter.md
Name: tl_merge_arbiter

Overview:
Egress-side counterpart of the transaction-layer demux. It collects 12-bit transaction words from four per-class input queues P0..P3 and merges them into one output queue. A strict-priority arbiter (P0 highest) performs the merge, throttled by programmable almost-full/almost-empty thresholds. Per-source forwarded-word counters are readable through the same req/idx/counter_valid/counter_out handshake as the ingress block.

Parameters:
DATA_W, 12, transaction word width
IN_DEPTH, 4, words per input FIFO
OUT_DEPTH, 8, words in the output FIFO
CNT_W, 5, counter width
UB_DEFAULT, 1, reset value of the low threshold
UA_DEFAULT, 6, reset value of the high threshold

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
init  in  1  threshold programming window
umbral_bajo  in  3  almost-empty threshold, sampled only while init=1
umbral_alto  in  3  almost-full threshold, sampled only while init=1
push_in_p0..p3  in  1 each  write strobe per input queue
data_in_p0..p3  in  12 each  input words
full_in_p0..p3  out  1 each  input FIFO full
pop_out  in  1  read strobe for the output FIFO
data_out  out  12  registered output word
empty_out  out  1  output FIFO empty
almost_full_out  out  1  output count >= umbral_alto
almost_empty_out  out  1  output count <= umbral_bajo
req  in  1  counter read request
idx  in  3  counter select
counter_valid  out  1  counter_out valid
counter_out  out  5  selected counter value
idle  out  1  FSM in IDLE
error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset values: all FIFOs empty; data_out=0; empty_out=1; almost_empty_out=1; full_in_*=0; almost_full_out=0; counters=0; counter_valid=0; counter_out=0; error=0; idle=0; thresholds=UB_DEFAULT/UA_DEFAULT; state=RESET.
- Reset asserted mid-operation: every FIFO and counter clears on that edge; in-flight words are dropped.
- FSM states are RESET, INIT, IDLE, ACTIVE.
  - RESET -> INIT when reset=0 and init=1; RESET -> IDLE when reset=0 and init=0.
  - INIT: thresholds are re-latched every cycle; init=0 -> IDLE.
  - IDLE -> ACTIVE when any input FIFO is non-empty.
  - ACTIVE -> IDLE when all input FIFOs are empty after the current transfer.
  - init=1 in IDLE/ACTIVE -> INIT; no transfers occur while in INIT.
  - idle=1 only in IDLE.
- Arbitration:
  - In ACTIVE, at most one word moves per cycle.
  - Source is the lowest-index non-empty input FIFO.
  - A transfer occurs only if the registered out_count < umbral_alto and out_count < OUT_DEPTH.
  - The forwarded word has bits [9:8] overwritten with the source index; all other bits pass unchanged.
- Latency: push at edge N -> word in input FIFO after N -> transferred at edge N+1 -> empty_out=0 after edge N+1. If not popped, data_out is valid after the pop edge N+2.
- Output FIFO:
  - pop_out with empty_out=0 loads data_out with the head word on that edge.
  - pop_out with empty_out=1 leaves data_out unchanged and sets error.
  - An internal write and a pop in the same cycle leave the count unchanged; both take effect.
- Input FIFOs:
  - A push while full_in_pX=1 drops the word and sets error.
  - Push and arbiter pop on the same FIFO in the same cycle are both legal.
- Thresholds: almost_full_out and almost_empty_out are registered and reflect out_count after the edge. With umbral_alto=0 no transfer ever occurs; this is legal and not an error.
- Counters:
  - cnt[k] increments by 1 per word forwarded from Pk and wraps 31 -> 0.
  - req=1 at edge N -> counter_valid=1 and counter_out=value after edge N.
  - idx 0..3 select cnt[idx]; idx 4 selects out_count; idx 5..7 return 0.
  - req=0 -> counter_valid=0 and counter_out holds its value.
  - Counters are not cleared by reads.
- error stays high until reset.

Decomposition:
- Package tl_pkg holds: DATA_W; the class field position [9:8]; the FSM state enum (2-bit, RESET=0, INIT=1, IDLE=2, ACTIVE=3); idx code constants (IDX_P0..IDX_P3=0..3, IDX_OCC=4).
- One sub-module, tl_sync_fifo (parameterised DEPTH and width, with push/pop/full/empty/count), instantiated five times.
- Arbiter, FSM and counters live in the top.

Test Plan:
- Reset with init=1 and umbral_alto=6, umbral_bajo=0, then release init -> idle=1, empty_out=1, thresholds latched at 6/0; changing umbral_alto to 2 afterwards has no effect.
- Push 0x001 to P3 and 0x002 to P0 on the same edge -> output order 0x002 then 0x301; cnt[0]=1, cnt[3]=1.
- Push 8 words into P1 without pop_out, umbral_alto=6 -> exactly 6 words transferred; almost_full_out=1; 2 remain in P1; full_in_p1=0. Pop once -> 1 more transfer.
- Push 5 words to P2 while arbitration is stalled (IN_DEPTH=4) -> 5th word dropped, error=1; pop_out on an empty output FIFO also sets error.
- Forward 33 words from P0, then req=1 with idx=0 -> counter_out=1 (wrapped), counter_valid=1; idx=4 -> current occupancy; idx=6 -> 0.
- Assert reset for 1 cycle mid-stream with 3 words queued -> empty_out=1, all counters 0, error=0, no stale word appears afterward.
